// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants used by the register file, the
// register-destination mux and the decoder.
package mips_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  typedef logic [ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;
  localparam reg_addr_t REG_RA   = 5'd31;

endpackage

// File: rtl/mips_regfile_rdport.sv
// One combinational read port: $0 forcing plus optional write-first
// forwarding (enabled by MIPS_REGFILE_BYPASS_EN).
module mips_regfile_rdport
  import mips_pkg::*;
#(
  parameter int DATA_W   = mips_pkg::DATA_W,
  parameter int ADDR_W   = mips_pkg::ADDR_W,
  parameter int NUM_REGS = 1 << ADDR_W
) (
  input  logic [ADDR_W-1:0]                  raddr,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]    regs,
  input  logic                               we,
  input  logic [ADDR_W-1:0]                  waddr,
  input  logic [DATA_W-1:0]                  wdata,
  output logic [DATA_W-1:0]                  rdata
);

`ifdef MIPS_REGFILE_BYPASS_EN
  always_comb begin
    rdata = '0;
    if (raddr != REG_ZERO) begin
      rdata = regs[raddr];
      if (we && (waddr == raddr)) begin
        rdata = wdata;
      end
    end
  end
`else
  logic unused_wr_side;
  assign unused_wr_side = ^{we, waddr, wdata};

  always_comb begin
    rdata = '0;
    if (raddr != REG_ZERO) begin
      rdata = regs[raddr];
    end
  end
`endif

endmodule

// File: rtl/mips_regfile.sv
// 32-entry MIPS register file: two combinational read ports, one write port,
// $0 hardwired to zero. Optional read bypass via MIPS_REGFILE_BYPASS_EN.
module mips_regfile
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [15:0]       wr_count
);

  localparam int NUM_REGS = 1 << ADDR_W;

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [15:0]                     count_q, count_d;
  logic                            we_fwd;

  always_comb begin
    regs_d  = regs_q;
    count_d = count_q;
    if (we && (waddr != REG_ZERO)) begin
      regs_d[waddr] = wdata;
      count_d       = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q  <= '0;
      count_q <= '0;
    end else begin
      regs_q  <= regs_d;
      count_q <= count_d;
    end
  end

  // Forwarding must not leak wdata onto the read ports while held in reset.
  assign we_fwd   = we & rst_n;
  assign wr_count = count_q;

  mips_regfile_rdport #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_rdport1 (
    .raddr (raddr1),
    .regs  (regs_q),
    .we    (we_fwd),
    .waddr (waddr),
    .wdata (wdata),
    .rdata (rdata1)
  );

  mips_regfile_rdport #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_rdport2 (
    .raddr (raddr2),
    .regs  (regs_q),
    .we    (we_fwd),
    .waddr (waddr),
    .wdata (wdata),
    .rdata (rdata2)
  );

endmodule

// File: tb/tb_mips_regfile.sv
// Directed self-checking bench for mips_regfile; expectations follow the
// build (MIPS_REGFILE_BYPASS_EN defined or not).
module tb_mips_regfile;

  logic        clk;
  logic        rst_n;
  logic [4:0]  raddr1, raddr2, waddr;
  logic [31:0] rdata1, rdata2, wdata;
  logic        we;
  logic [15:0] wr_count;

  int checks   = 0;
  int failures = 0;

  mips_regfile dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .raddr1   (raddr1),
    .raddr2   (raddr2),
    .rdata1   (rdata1),
    .rdata2   (rdata2),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .wr_count (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 ns after the rising edge, well away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    step();
    we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
    #20;
    raddr1 = 5'd5; raddr2 = 5'd31;
    #1;
    checks++;
    if (rdata1 !== 32'd0) begin failures++; $display("FAIL reset_rdata1 got=%h exp=%h", rdata1, 32'd0); end
    checks++;
    if (rdata2 !== 32'd0) begin failures++; $display("FAIL reset_rdata2 got=%h exp=%h", rdata2, 32'd0); end
    checks++;
    if (wr_count !== 16'd0) begin failures++; $display("FAIL reset_wr_count got=%0d exp=%0d", wr_count, 0); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic_write();
    write_reg(5'd5, 32'h0000_0007);
    raddr1 = 5'd5;
    #1;
    checks++;
    if (rdata1 !== 32'd7) begin failures++; $display("FAIL basic_r5 got=%h exp=%h", rdata1, 32'd7); end
    checks++;
    if (wr_count !== 16'd1) begin failures++; $display("FAIL basic_count1 got=%0d exp=%0d", wr_count, 1); end
    write_reg(5'd7, 32'h0000_0005);
    raddr2 = 5'd7;
    #1;
    checks++;
    if (rdata2 !== 32'd5) begin failures++; $display("FAIL basic_r7 got=%h exp=%h", rdata2, 32'd5); end
    checks++;
    if (rdata1 !== 32'd7) begin failures++; $display("FAIL basic_r5_kept got=%h exp=%h", rdata1, 32'd7); end
    checks++;
    if (wr_count !== 16'd2) begin failures++; $display("FAIL basic_count2 got=%0d exp=%0d", wr_count, 2); end
  endtask

  task automatic test_same_addr();
    raddr1 = 5'd7; raddr2 = 5'd7;
    #1;
    checks++;
    if (rdata1 !== 32'd5 || rdata2 !== 32'd5) begin
      failures++; $display("FAIL same_addr got1=%h got2=%h exp=%h", rdata1, rdata2, 32'd5);
    end
  endtask

  task automatic test_zero_write();
    raddr1 = 5'd0; raddr2 = 5'd5;
    we = 1'b1; waddr = 5'd0; wdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (rdata1 !== 32'd0) begin failures++; $display("FAIL zero_fwd got=%h exp=%h", rdata1, 32'd0); end
    step();
    we = 1'b0;
    #1;
    checks++;
    if (rdata1 !== 32'd0) begin failures++; $display("FAIL zero_read got=%h exp=%h", rdata1, 32'd0); end
    checks++;
    if (rdata2 !== 32'd7) begin failures++; $display("FAIL zero_r5_kept got=%h exp=%h", rdata2, 32'd7); end
    checks++;
    if (wr_count !== 16'd2) begin failures++; $display("FAIL zero_count got=%0d exp=%0d", wr_count, 2); end
  endtask

  task automatic test_same_cycle();
    logic [31:0] exp_pre;
`ifdef MIPS_REGFILE_BYPASS_EN
    exp_pre = 32'h0000_1234;
`else
    exp_pre = 32'h0000_0005;
`endif
    raddr1 = 5'd7; raddr2 = 5'd5;
    we = 1'b1; waddr = 5'd7; wdata = 32'h0000_1234;
    #1;
    checks++;
    if (rdata1 !== exp_pre) begin failures++; $display("FAIL same_cycle_pre got=%h exp=%h", rdata1, exp_pre); end
    checks++;
    if (rdata2 !== 32'd7) begin failures++; $display("FAIL same_cycle_other got=%h exp=%h", rdata2, 32'd7); end
    step();
    we = 1'b0;
    #1;
    checks++;
    if (rdata1 !== 32'h0000_1234) begin failures++; $display("FAIL same_cycle_post got=%h exp=%h", rdata1, 32'h1234); end
    checks++;
    if (wr_count !== 16'd3) begin failures++; $display("FAIL same_cycle_count got=%0d exp=%0d", wr_count, 3); end
  endtask

  task automatic test_async_reset();
    raddr1 = 5'd5; raddr2 = 5'd7;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rdata1 !== 32'd0 || rdata2 !== 32'd0) begin
      failures++; $display("FAIL async_rst_read got1=%h got2=%h exp=%h", rdata1, rdata2, 32'd0);
    end
    checks++;
    if (wr_count !== 16'd0) begin failures++; $display("FAIL async_rst_count got=%0d exp=%0d", wr_count, 0); end
    raddr1 = 5'd9;
    we = 1'b1; waddr = 5'd9; wdata = 32'h0000_0ABC;
    #1;
    checks++;
    if (rdata1 !== 32'd0) begin failures++; $display("FAIL rst_no_fwd got=%h exp=%h", rdata1, 32'd0); end
    step();
    we = 1'b0;
    // Arm a write, then release reset mid-cycle; it must commit on the next edge.
    we = 1'b1; waddr = 5'd3; wdata = 32'h0000_0033;
    #2;
    rst_n = 1'b1;
    step();
    we = 1'b0;
    raddr2 = 5'd3;
    #1;
    checks++;
    if (rdata1 !== 32'd0) begin failures++; $display("FAIL rst_write_ignored got=%h exp=%h", rdata1, 32'd0); end
    checks++;
    if (rdata2 !== 32'h0000_0033) begin failures++; $display("FAIL rst_release_write got=%h exp=%h", rdata2, 32'h33); end
    checks++;
    if (wr_count !== 16'd1) begin failures++; $display("FAIL rst_release_count got=%0d exp=%0d", wr_count, 1); end
  endtask

  task automatic test_wrap();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #2;
    raddr1 = 5'd1;
    we = 1'b1; waddr = 5'd1;
    for (int i = 1; i <= 65536; i++) begin
      wdata = i;
      step();
      if (i == 65535) begin
        checks++;
        if (wr_count !== 16'hFFFF) begin failures++; $display("FAIL wrap_ffff got=%h exp=%h", wr_count, 16'hFFFF); end
      end
    end
    we = 1'b0;
    #1;
    checks++;
    if (wr_count !== 16'd0) begin failures++; $display("FAIL wrap_zero got=%h exp=%h", wr_count, 16'h0); end
    checks++;
    if (rdata1 !== 32'h0001_0000) begin failures++; $display("FAIL wrap_r1 got=%h exp=%h", rdata1, 32'h10000); end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_same_addr();
    test_zero_write();
    test_same_cycle();
    test_async_reset();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mips_regfile.md
# mips_regfile

Architectural register file for the single-cycle MIPS datapath. It sits directly downstream of the 5-bit register-destination mux, which selects rt or rd, and consumes that mux's output as its write address. It provides two combinational read ports (rs, rt) that feed the ALU and the store-data path. It holds one synchronous write port that commits the write-back result on the rising clock edge, and register $0 is hardwired to zero.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width (32 entries)

Ports:
- clk  input  1  sole clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- raddr1  input  ADDR_W  read port 1 address (instruction rs field)
- raddr2  input  ADDR_W  read port 2 address (instruction rt field)
- rdata1  output  DATA_W  read port 1 data
- rdata2  output  DATA_W  read port 2 data
- we  input  1  write enable (RegWrite control)
- waddr  input  ADDR_W  write address, driven by the register-destination mux output
- wdata  input  DATA_W  write-back data (ALU result or load data)
- wr_count  output  16  count of committed writes since reset, for bench/debug observation

## Operation
- Storage is 32 x DATA_W flops; entry 0 is never written and always reads as 0.
- Write: on a rising clk edge with we=1 and waddr!=0, entry[waddr] <= wdata, and wr_count increments by 1.
- Write to $0 (we=1, waddr=0): it is discarded, the storage is unchanged, and wr_count does not increment.
- wr_count wraps modulo 2^16 (16'hFFFF -> 16'h0000), with no saturation.
- Read: rdata1 = entry[raddr1] and rdata2 = entry[raddr2], purely combinational from the address and the current storage.
- raddr1 == raddr2 is legal, and both ports return identical data.
- Reset: asserting rst_n=0 clears every entry to 0 and wr_count to 0 immediately, with no clock required. While rst_n=0, rdata1 and rdata2 read 0 and writes are ignored.
- Reset deasserted mid-cycle: the first write is accepted on the first rising edge on which rst_n is sampled high.
- Undefined or X addresses are not allowed from the datapath. The verifier asserts that waddr is known whenever we=1.

## Timing
- Read latency is 0 cycles (combinational, same cycle as the address).
- Write latency is 1 edge. The new value is visible on a read port after the rising edge that commits it.
- Same-cycle read of the address being written returns the old value, unless bypass is enabled (see Configuration).
- Reset values: rdata1=0, rdata2=0, wr_count=0.
- Async reset assertion takes priority over a simultaneous write edge.

## Configuration
- Macro: MIPS_REGFILE_BYPASS_EN.
- Defined: each read port checks we && waddr==raddrN && waddr!=0. On a match, rdataN = wdata in the same cycle (write-first forwarding). Reads of $0 still return 0.
- Undefined: no forwarding, and reads always reflect the stored contents (read-before-write).
- Storage, write behaviour and wr_count are identical in both builds.

## Structure
- Shared package mips_pkg holds the following constants, used by this block, the register-destination mux and the decoder:
  - DATA_W=32, ADDR_W=5, NUM_REGS=32
  - REG_ZERO=5'd0, REG_RA=5'd31
- One sub-module, mips_regfile_rdport, is instantiated twice. It takes the address, the storage array view, and the write-side signals. It outputs the read data, with the zero-register forcing and the optional bypass mux, so the bypass logic lives in one place.
- The top level holds the storage array, the write logic and wr_count.

## Test plan
- Reset then read: rst_n=0 for 20 ns, then raddr1=5 and raddr2=31 -> rdata1=0, rdata2=0, wr_count=0.
- Basic write/read: we=1, waddr=5, wdata=32'h0000_0007 for one edge, then raddr1=5 -> rdata1=7 and wr_count=1. Repeat with waddr=7, wdata=5, then raddr2=7 -> rdata2=5 and wr_count=2.
- $0 protection: we=1, waddr=0, wdata=32'hDEAD_BEEF for one edge, then raddr1=0 -> rdata1=0, and wr_count is unchanged.
- Same-cycle read/write of reg 7 (holding 5) with wdata=32'h1234, before the edge:
  - bypass build -> rdata1=32'h1234
  - non-bypass build -> rdata1=5
  - after the edge, both builds -> 32'h1234.
- Async reset mid-operation: after writing regs 5 and 7, pull rst_n low between edges -> rdata for both reads 0 within the same cycle, wr_count=0, and a write during reset is ignored.
- Counter wrap: preload via 65536 writes to reg 1 -> wr_count returns to 0, and reg 1 holds the last wdata.
